rx_op_sequencer: RTL and testbench

- Controller between the nibble receive interface (rx_byte/rx_dv) and the ML processor datapath.
- Loads NUM_OPERANDS 4-bit operands into the datapath operand store.
- On a run-switch rising edge, it starts the datapath, waits for completion with a timeout, and latches the result.
- Exports state and result for the HEX display logic.

---
 rtl/rx_op_sequencer_pkg.sv | 29 ++
 rtl/rx_op_sequencer_if.sv | 34 +++
 rtl/rx_op_sequencer_sw_sync_edge.sv | 37 +++
 rtl/rx_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rx_op_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_op_sequencer_pkg.sv
// Shared definitions for the operand-load / run sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding (fixed values, read by the HEX display logic),
// default parameter values and a counter-width helper.

package rx_op_sequencer_pkg;

    // Encoding is visible on the state output, so the values are fixed.
    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_FULL  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } seq_state_e;

    localparam int NUM_OPERANDS_DEF = 4;
    localparam int RES_W_DEF        = 8;
    localparam int TIMEOUT_DEF      = 255;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rx_op_sequencer_if.sv
// Bus bundle between the sequencer, the nibble receiver and the ML datapath.
// Latency: n/a (wires only).
// Backpressure: none; rx_dv is a one-cycle strobe, dp_done a completion flag.
//
// Signals:
//   rx_byte/rx_dv                    received nibble and its valid strobe
//   op_wr_en/op_wr_addr/op_wr_data   operand store write port
//   dp_start                         one-cycle datapath start pulse
//   dp_done/dp_result                datapath completion and result
// Modports: master = sequencer side, slave = receiver/datapath side.

interface rx_op_sequencer_if #(
    parameter int ADDR_W = 2,
    parameter int RES_W  = 8
);
    logic [3:0]        rx_byte;
    logic              rx_dv;
    logic              op_wr_en;
    logic [ADDR_W-1:0] op_wr_addr;
    logic [3:0]        op_wr_data;
    logic              dp_start;
    logic              dp_done;
    logic [RES_W-1:0]  dp_result;

    modport master (
        input  rx_byte, rx_dv, dp_done, dp_result,
        output op_wr_en, op_wr_addr, op_wr_data, dp_start
    );

    modport slave (
        output rx_byte, rx_dv, dp_done, dp_result,
        input  op_wr_en, op_wr_addr, op_wr_data, dp_start
    );
endinterface

// File: rtl/rx_op_sequencer_sw_sync_edge.sv
// Synchronises a slow asynchronous switch/key level and flags its edges.
// Latency: an input change shows up on rise/fall after the 2nd clock edge,
//          so logic clocked by the same edge acts on it at the 3rd.
// Backpressure: none; rise/fall are single-cycle pulses.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   sw         raw asynchronous level
//   rise/fall  one-cycle pulses on a synchronised 0->1 / 1->0 change

module sw_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic rise,
    output logic fall
);
    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= sw;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~prev_q;
    assign fall = ~sync_q2 & prev_q;

endmodule

// File: rtl/rx_op_sequencer.sv
// Loads NUM_OPERANDS nibbles into the datapath, runs it on a switch edge, latches the result.
// Latency: operand write is combinational with rx_dv; dp_start 3 cycles after run_sw rises.
// Backpressure: none; nibbles arriving when no write is possible are dropped (flagged in FULL).
//
// Ports:
//   CLOCK_50, reset    clock, asynchronous active-high reset
//   run_sw             asynchronous run switch level
//   bus (master)       nibble input, operand write port, datapath start/done/result
//   result/result_valid  latched datapath result and "holds a completed run"
//   load_count         operands loaded so far (saturates at NUM_OPERANDS)
//   state              encoded FSM state for the HEX display
//   overflow           sticky: nibble received while FULL
//   error              datapath timed out

module rx_op_sequencer
    import rx_op_sequencer_pkg::*;
#(
    parameter int NUM_OPERANDS = NUM_OPERANDS_DEF,
    parameter int ADDR_W       = $clog2(NUM_OPERANDS),
    parameter int RES_W        = RES_W_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                run_sw,
    rx_op_sequencer_if.master   bus,
    output logic [RES_W-1:0]    result,
    output logic                result_valid,
    output logic [ADDR_W:0]     load_count,
    output logic [2:0]          state,
    output logic                overflow,
    output logic                error
);
    localparam int LC_W = ADDR_W + 1;
    localparam int TO_W = cnt_w(TIMEOUT);

    localparam logic [LC_W-1:0] LAST_IDX = LC_W'(NUM_OPERANDS - 1);
    localparam logic [LC_W-1:0] FULL_CNT = LC_W'(NUM_OPERANDS);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    seq_state_e      state_q;
    seq_state_e      state_d;
    logic [TO_W-1:0] wait_cnt_q;

    logic sw_rise;
    logic sw_fall;

    // Control strobes decoded by the FSM, consumed by the datapath registers.
    logic accept;       // nibble written to the operand store
    logic ovf_set;      // nibble arrived while FULL
    logic clr_run;      // returning to LOAD from DONE/ERR
    logic done_hit;     // datapath finished inside the wait window
    logic timeout_hit;  // wait window exhausted

    sw_sync_edge u_run_sync (
        .clk  (CLOCK_50),
        .rst  (reset),
        .sw   (run_sw),
        .rise (sw_rise),
        .fall (sw_fall)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        ovf_set     = 1'b0;
        clr_run     = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // A rise here is deliberately ignored: no partial runs. If it
                // coincides with the final nibble it is lost too, and the user
                // has to toggle run_sw again.
                if (bus.rx_dv && (load_count != FULL_CNT)) begin
                    accept = 1'b1;
                    if (load_count == LAST_IDX) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (bus.rx_dv) begin
                    ovf_set = 1'b1;
                end
                if (sw_rise) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is checked first so a done on the final cycle
                // of the window still counts as a successful run.
                if (bus.dp_done) begin
                    done_hit = 1'b1;
                    state_d  = ST_DONE;
                end else if (wait_cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (sw_fall) begin
                    clr_run = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Load counter, sticky flags, result latch and wait-window counter.
    // The wait counter is cleared in START so WAIT always begins at 0; it
    // allows exactly TIMEOUT WAIT cycles before declaring a timeout.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            load_count   <= '0;
            overflow     <= 1'b0;
            error        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            if (accept) begin
                load_count <= load_count + LC_W'(1);
            end else if (clr_run) begin
                load_count <= '0;
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_run) begin
                overflow <= 1'b0;
            end

            if (timeout_hit) begin
                error <= 1'b1;
            end else if (clr_run) begin
                error <= 1'b0;
            end

            // result/result_valid survive the return to LOAD and are only
            // invalidated when the next run actually starts.
            if (state_q == ST_START) begin
                result_valid <= 1'b0;
            end else if (done_hit) begin
                result       <= bus.dp_result;
                result_valid <= 1'b1;
            end

            if (state_q == ST_START) begin
                wait_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + TO_W'(1);
            end
        end
    end

    assign bus.op_wr_en   = accept;
    assign bus.op_wr_addr = load_count[ADDR_W-1:0];
    assign bus.op_wr_data = accept ? bus.rx_byte : 4'h0;
    assign bus.dp_start   = (state_q == ST_START);

    assign state = state_q;

endmodule

// File: tb/tb_rx_op_sequencer.sv
// Self-checking bench for rx_op_sequencer with randomized nibbles, datapath delays and results.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).

module tb_rx_op_sequencer;

    localparam int NUM_OPERANDS = 4;
    localparam int ADDR_W       = 2;
    localparam int RES_W        = 8;
    localparam int TIMEOUT      = 16;

    // State codes as published for the HEX display.
    localparam int S_LOAD  = 0;
    localparam int S_FULL  = 1;
    localparam int S_START = 2;
    localparam int S_WAIT  = 3;
    localparam int S_DONE  = 4;
    localparam int S_ERR   = 5;

    logic              CLOCK_50 = 1'b0;
    logic              reset    = 1'b1;
    logic              run_sw   = 1'b0;
    logic [RES_W-1:0]  result;
    logic              result_valid;
    logic [ADDR_W:0]   load_count;
    logic [2:0]        state;
    logic              overflow;
    logic              error;

    rx_op_sequencer_if #(.ADDR_W(ADDR_W), .RES_W(RES_W)) ifc ();

    rx_op_sequencer #(
        .NUM_OPERANDS (NUM_OPERANDS),
        .ADDR_W       (ADDR_W),
        .RES_W        (RES_W),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .run_sw       (run_sw),
        .bus          (ifc),
        .result       (result),
        .result_valid (result_valid),
        .load_count   (load_count),
        .state        (state),
        .overflow     (overflow),
        .error        (error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters gathered away from the clock edge.
    int n_start  = 0;
    int n_wait   = 0;
    int n_bad_wr = 0;

    always @(negedge CLOCK_50) begin
        if (ifc.dp_start === 1'b1) n_start++;
        if (state == 3'(S_WAIT)) n_wait++;
        if (ifc.op_wr_en === 1'b1 && state != 3'(S_LOAD)) n_bad_wr++;
    end

    // Reference model: what the user-visible registers should hold.
    int         m_count = 0;
    bit         m_ovf   = 1'b0;
    bit         m_err   = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] m_res   = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_all(input string tag, input int exp_state);
        chk({tag, ":state"},        32'(state),        32'(exp_state));
        chk({tag, ":load_count"},   32'(load_count),   32'(m_count));
        chk({tag, ":overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ":error"},        32'(error),        32'(m_err));
        chk({tag, ":result"},       32'(result),       32'(m_res));
        chk({tag, ":result_valid"}, 32'(result_valid), 32'(m_valid));
        chk({tag, ":dp_start"},     32'(ifc.dp_start), 32'(exp_state == S_START));
    endtask

    // One-cycle nibble strobe followed by `gap` idle cycles.
    task automatic send(input logic [3:0] d, input int gap, input bit exp_wr);
        ifc.rx_byte = d;
        ifc.rx_dv   = 1'b1;
        @(negedge CLOCK_50);
        chk("wr_en", 32'(ifc.op_wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", 32'(ifc.op_wr_addr), 32'(m_count));
            chk("wr_data", 32'(ifc.op_wr_data), 32'(d));
        end
        tick();
        ifc.rx_dv   = 1'b0;
        ifc.rx_byte = 4'($urandom);
        if (exp_wr) m_count++;
        repeat (gap) tick();
    endtask

    task automatic load_rand();
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            send(4'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    // Raise run_sw from FULL, let the datapath answer after `delay` WAIT
    // cycles (delay > TIMEOUT means it never answers).
    task automatic run_op(input int delay, input logic [7:0] res);
        int s0;
        int w0;
        int lat;
        int k;
        s0  = n_start;
        w0  = n_wait;
        run_sw = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ifc.dp_start !== 1'b1 && lat < 12);
        chk("start_latency", 32'(lat), 32'd3);
        m_valid = 1'b0;
        if (delay <= TIMEOUT) begin
            repeat (delay) tick();
            ifc.dp_done   = 1'b1;
            ifc.dp_result = res;
            tick();
            ifc.dp_done   = 1'b0;
            ifc.dp_result = ~res;
            m_res   = res;
            m_valid = 1'b1;
            chk("wait_cycles", 32'(n_wait - w0), 32'(delay));
            check_all("done", S_DONE);
        end else begin
            k = 0;
            while (state !== 3'(S_ERR) && k < TIMEOUT + 8) begin
                tick();
                k++;
            end
            m_err = 1'b1;
            chk("timeout_cycles", 32'(n_wait - w0), 32'(TIMEOUT));
            check_all("timeout", S_ERR);
        end
        chk("start_pulses", 32'(n_start - s0), 32'd1);
    endtask

    task automatic lower_sw();
        run_sw = 1'b0;
        repeat (3) tick();
        m_count = 0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        check_all("lower", S_LOAD);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int k;
        ifc.rx_byte   = 4'h0;
        ifc.rx_dv     = 1'b0;
        ifc.dp_done   = 1'b0;
        ifc.dp_result = '0;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_all("reset", S_LOAD);
        chk("reset:wr_en", 32'(ifc.op_wr_en), 32'd0);
        reset = 1'b0;
        tick();

        // Fixed load 1,2,3,8 with gaps of 1 and 10 cycles
        send(4'h1, 1, 1'b1);
        send(4'h2, 10, 1'b1);
        send(4'h3, 1, 1'b1);
        send(4'h8, 10, 1'b1);
        check_all("load_full", S_FULL);
        chk("no_start_in_load", 32'(n_start), 32'd0);

        // Nibble while FULL: no write, sticky overflow
        send(4'hF, 2, 1'b0);
        m_ovf = 1'b1;
        check_all("overflow", S_FULL);

        // Run with a 5-cycle datapath returning 0x0E
        run_op(5, 8'h0E);

        // dp_done outside WAIT is ignored
        ifc.dp_done   = 1'b1;
        ifc.dp_result = 8'h77;
        tick();
        ifc.dp_done   = 1'b0;
        check_all("late_done", S_DONE);

        lower_sw();

        // Datapath never answers
        load_rand();
        run_op(TIMEOUT + 5, 8'($urandom));
        lower_sw();

        // Rise after only 2 nibbles is ignored
        send(4'($urandom), 0, 1'b1);
        send(4'($urandom), 1, 1'b1);
        s0 = n_start;
        run_sw = 1'b1;
        repeat (6) tick();
        check_all("partial_rise", S_LOAD);
        chk("partial_no_start", 32'(n_start - s0), 32'd0);
        run_sw = 1'b0;
        repeat (4) tick();
        check_all("partial_fall", S_LOAD);

        // Final nibble lands on the same cycle the rise is seen
        send(4'($urandom), 0, 1'b1);
        run_sw = 1'b1;
        tick();
        tick();
        send(4'($urandom), 0, 1'b1);
        repeat (6) tick();
        check_all("final_rise", S_FULL);
        chk("final_rise_no_start", 32'(n_start - s0), 32'd0);
        run_sw = 1'b0;
        repeat (4) tick();
        check_all("full_fall", S_FULL);
        run_op(int'($urandom_range(1, TIMEOUT)), 8'($urandom));
        lower_sw();

        // Randomized runs, including both ends of the wait window
        for (int it = 0; it < 6; it++) begin
            int d;
            load_rand();
            if ($urandom_range(0, 1) == 1) begin
                send(4'($urandom), 0, 1'b0);
                m_ovf = 1'b1;
            end
            check_all("rnd_full", S_FULL);
            d = (it == 0) ? TIMEOUT :
                (it == 1) ? TIMEOUT + 1 : int'($urandom_range(1, TIMEOUT + 4));
            run_op(d, 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                send(4'($urandom), 0, 1'b0);
            end
            check_all("rnd_hold", (d <= TIMEOUT) ? S_DONE : S_ERR);
            lower_sw();
        end

        // Reset in the middle of WAIT, then a stray dp_done
        load_rand();
        run_sw = 1'b1;
        k = 0;
        while (ifc.dp_start !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk("pre_reset_wait", 32'(state), 32'(S_WAIT));
        reset = 1'b1;
        #1;
        m_count = 0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_res   = 8'h00;
        check_all("reset_wait", S_LOAD);
        tick();
        reset = 1'b0;
        ifc.dp_done   = 1'b1;
        ifc.dp_result = 8'hA5;
        tick();
        ifc.dp_done   = 1'b0;
        check_all("reset_late_done", S_LOAD);
        s0 = n_start;
        repeat (8) tick();
        chk("reset_no_restart", 32'(n_start - s0), 32'd0);
        check_all("reset_idle", S_LOAD);
        run_sw = 1'b0;
        repeat (4) tick();

        chk("wr_outside_load", 32'(n_bad_wr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
